// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator-machine control unit: opcodes,
// FSM states, ALU operation codes, instruction classes and address selects.
package ac_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_INAC = 4'h6;
  localparam logic [3:0] OP_CLAC = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JMPZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_IR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_REG, CLS_MEM, CLS_JUMP, CLS_HALT, CLS_ILL
  } iclass_t;

endpackage

// File: rtl/ac_ctrl_if.sv
// Memory-port handshake between the control unit and the shared memory.
interface ac_ctrl_if;
  logic mem_req;
  logic mem_ack;
  logic mem_we;
  logic addr_sel;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ack);
endinterface

// File: rtl/ac_decode.sv
// Combinational opcode classifier: instruction class, ALU operation and
// write qualifier for the memory phase.
module ac_decode
  import ac_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output iclass_t        cls,
  output logic [1:0]     alu_op,
  output logic           mem_we,
  output logic           alu_en
);

  always_comb begin
    cls    = CLS_ILL;
    alu_op = ALU_PASS;
    mem_we = 1'b0;
    alu_en = 1'b0;
    case (opcode)
      OPW'(OP_NOP), OPW'(OP_INAC), OPW'(OP_CLAC): cls = CLS_REG;
      OPW'(OP_JMP), OPW'(OP_JMPZ):                cls = CLS_JUMP;
      OPW'(OP_LDAC):                              cls = CLS_MEM;
      OPW'(OP_STAC): begin
        cls    = CLS_MEM;
        mem_we = 1'b1;
      end
      OPW'(OP_ADD): begin
        cls    = CLS_MEM;
        alu_en = 1'b1;
        alu_op = ALU_ADD;
      end
      OPW'(OP_SUB): begin
        cls    = CLS_MEM;
        alu_en = 1'b1;
        alu_op = ALU_SUB;
      end
      OPW'(OP_AND): begin
        cls    = CLS_MEM;
        alu_en = 1'b1;
        alu_op = ALU_AND;
      end
      OPW'(OP_HALT):                              cls = CLS_HALT;
      default:                                    cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/ac_ctrl.sv
// Fetch/decode/memory sequencer for the 12-bit accumulator datapath.
// Outputs are decoded from the registered state plus mem_ack/ir_opcode/ac_zero.
module ac_ctrl
  import ac_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] ir_opcode,
  input  logic           ac_zero,
  ac_ctrl_if.master      bus,
  output logic           ir_load,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           ac_write_en,
  output logic           ac_alu_to_ac,
  output logic           ac_inc_en,
  output logic           ac_clr_en,
  output logic [1:0]     alu_op,
  output logic           busy,
  output logic           halted,
  output logic           illegal
);

  state_t     state;
  iclass_t    dec_cls;
  logic [1:0] dec_alu_op;
  logic       dec_we;
  logic       dec_alu_en;

  ac_decode #(.OPW(OPW)) u_dec (
    .opcode (ir_opcode),
    .cls    (dec_cls),
    .alu_op (dec_alu_op),
    .mem_we (dec_we),
    .alu_en (dec_alu_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_FETCH;
        S_FETCH: if (bus.mem_ack) state <= S_DECODE;
        S_DECODE: begin
          case (dec_cls)
            CLS_MEM:  state <= S_MEM;
            CLS_HALT: state <= S_HALT;
            CLS_ILL: begin
              illegal <= 1'b1;
              state   <= S_FETCH;
            end
            default:  state <= S_FETCH;
          endcase
        end
        S_MEM:   if (bus.mem_ack) state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes fire only in the ack cycle of FETCH/MEM or the single DECODE cycle.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = ADDR_PC;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ac_write_en  = 1'b0;
    ac_alu_to_ac = 1'b0;
    ac_inc_en    = 1'b0;
    ac_clr_en    = 1'b0;
    alu_op       = ALU_PASS;
    halted       = 1'b0;
    busy         = (state == S_FETCH) || (state == S_DECODE) || (state == S_MEM);
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
      end
      S_DECODE: begin
        ac_inc_en = (ir_opcode == OPW'(OP_INAC));
        ac_clr_en = (ir_opcode == OPW'(OP_CLAC));
        pc_load   = (ir_opcode == OPW'(OP_JMP)) ||
                    ((ir_opcode == OPW'(OP_JMPZ)) && ac_zero);
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = ADDR_IR;
        bus.mem_we   = dec_we;
        alu_op       = dec_alu_en ? dec_alu_op : ALU_PASS;
        if (bus.mem_ack) begin
          ac_write_en  = (ir_opcode == OPW'(OP_LDAC));
          ac_alu_to_ac = dec_alu_en;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ac_ctrl.sv
// Bench for ac_ctrl: a directed vector table, hand-written reset corner cases
// and a random instruction stream checked against a per-instruction trace model.
module tb_ac_ctrl;
  import ac_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, ac_zero;
  logic [3:0] ir_opcode;
  logic       ir_load, pc_inc, pc_load, ac_write_en, ac_alu_to_ac, ac_inc_en, ac_clr_en;
  logic [1:0] alu_op;
  logic       busy, halted, illegal;

  ac_ctrl_if bus();

  ac_ctrl #(.OPW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ir_opcode    (ir_opcode),
    .ac_zero      (ac_zero),
    .bus          (bus),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .ac_write_en  (ac_write_en),
    .ac_alu_to_ac (ac_alu_to_ac),
    .ac_inc_en    (ac_inc_en),
    .ac_clr_en    (ac_clr_en),
    .alu_op       (alu_op),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  // Strobe order: req, we, addr_sel, ir_load, pc_inc, pc_load, wr, alu, inc, clr
  typedef struct packed {
    logic       req, we, asel, irl, pci, pcl, wr, alu, inc, clr;
    logic [1:0] aop;
    logic       busy, halted, ill;
  } ovec_t;

  typedef struct {
    logic       st;
    logic       ack;
    logic [3:0] op;
    logic       az;
    ovec_t      exp;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    int         fw;
    int         mw;
    logic       az;
  } instr_t;

  int         n_chk = 0;
  int         n_fail = 0;
  logic       model_ill = 1'b0;
  logic [3:0] cur_op = 4'h0;
  vec_t       tbl[10];
  instr_t     dir[14];

  function automatic ovec_t e(input logic [9:0] s, input logic [1:0] a, input logic [2:0] f);
    return ovec_t'({s, a, f});
  endfunction

  task automatic step(input logic st, input logic r, input logic ack, input logic [3:0] op,
                      input logic az, input logic chk, input ovec_t exp, input string nm);
    ovec_t act;
    start = st; rst = r; bus.mem_ack = ack; ir_opcode = op; ac_zero = az;
    @(negedge clk);
    act = {bus.mem_req, bus.mem_we, bus.addr_sel, ir_load, pc_inc, pc_load, ac_write_en,
           ac_alu_to_ac, ac_inc_en, ac_clr_en, alu_op, busy, halted, illegal};
    if (chk) begin
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: outputs got %b required %b", nm, act, exp);
      end
      n_chk++;
      if ($countones({ac_write_en, ac_alu_to_ac, ac_inc_en, ac_clr_en}) > 1 || (pc_inc && pc_load)) begin
        n_fail++;
        $display("FAIL %s_invariant: strobes got %b required one-hot-or-zero", nm, act);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0, cur_op, 1'b0, 1'b0, '0, "rst_enter");
    step(1'b1, 1'b1, 1'b1, cur_op, 1'b0, 1'b1, e(10'b0, 2'b11, 3'b000), "reset_state");
    model_ill = 1'b0;
  endtask

  task automatic go();
    step(1'b1, 1'b0, 1'($urandom_range(0, 1)), cur_op, 1'b0, 1'b1,
         e(10'b0, 2'b11, {2'b00, model_ill}), "start");
  endtask

  // Expand one instruction into its expected cycle trace from the ISA rules.
  task automatic exec(input instr_t i, input string nm);
    logic [9:0] s;
    logic       mem_cls, alu_cls;
    logic [1:0] code;
    for (int k = 0; k < i.fw; k++)
      step(1'b0, 1'b0, 1'b0, cur_op, i.az, 1'b1, e(10'b1000000000, 2'b11, {2'b10, model_ill}), {nm, "_fwait"});
    step(1'b0, 1'b0, 1'b1, cur_op, i.az, 1'b1, e(10'b1001100000, 2'b11, {2'b10, model_ill}), {nm, "_fack"});
    cur_op = i.op;
    s = '0;
    s[1] = (i.op == OP_INAC);
    s[0] = (i.op == OP_CLAC);
    s[4] = (i.op == OP_JMP) || (i.op == OP_JMPZ && i.az);
    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), cur_op, i.az, 1'b1, e(s, 2'b11, {2'b10, model_ill}), {nm, "_decode"});
    if (i.op >= 4'hA && i.op <= 4'hE) model_ill = 1'b1;
    mem_cls = (i.op >= OP_LDAC && i.op <= OP_AND);
    alu_cls = (i.op >= OP_ADD && i.op <= OP_AND);
    code    = (i.op == OP_ADD) ? 2'b00 : (i.op == OP_SUB) ? 2'b01 : 2'b10;
    if (mem_cls) begin
      s = {1'b1, i.op == OP_STAC, 1'b1, 7'b0};
      for (int k = 0; k < i.mw; k++)
        step(1'b0, 1'b0, 1'b0, cur_op, i.az, 1'b1, e(s, alu_cls ? code : 2'b11, {2'b10, model_ill}), {nm, "_mwait"});
      s[3] = (i.op == OP_LDAC);
      s[2] = alu_cls;
      step(1'b0, 1'b0, 1'b1, cur_op, i.az, 1'b1, e(s, alu_cls ? code : 2'b11, {2'b10, model_ill}), {nm, "_mack"});
    end
    if (i.op == OP_HALT) begin
      for (int k = 0; k < 2; k++)
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)), cur_op, i.az, 1'b1,
             e(10'b0, 2'b11, {2'b01, model_ill}), {nm, "_halted"});
    end
  endtask

  initial begin
    instr_t ri;
    tbl[0] = '{1'b1, 1'b0, 4'h0, 1'b0, e(10'b0000000000, 2'b11, 3'b000)};
    tbl[1] = '{1'b0, 1'b1, 4'h0, 1'b0, e(10'b1001100000, 2'b11, 3'b100)};
    tbl[2] = '{1'b0, 1'b0, 4'h6, 1'b0, e(10'b0000000010, 2'b11, 3'b100)};
    tbl[3] = '{1'b0, 1'b1, 4'h6, 1'b0, e(10'b1001100000, 2'b11, 3'b100)};
    tbl[4] = '{1'b0, 1'b0, 4'h6, 1'b0, e(10'b0000000010, 2'b11, 3'b100)};
    tbl[5] = '{1'b0, 1'b1, 4'h6, 1'b0, e(10'b1001100000, 2'b11, 3'b100)};
    tbl[6] = '{1'b0, 1'b0, 4'hF, 1'b0, e(10'b0000000000, 2'b11, 3'b100)};
    tbl[7] = '{1'b1, 1'b1, 4'hF, 1'b0, e(10'b0000000000, 2'b11, 3'b010)};
    tbl[8] = '{1'b1, 1'b0, 4'hF, 1'b0, e(10'b0000000000, 2'b11, 3'b010)};
    tbl[9] = '{1'b0, 1'b0, 4'hF, 1'b0, e(10'b0000000000, 2'b11, 3'b010)};

    dir[0]  = '{OP_LDAC, 0, 3, 1'b0};
    dir[1]  = '{OP_ADD,  1, 0, 1'b0};
    dir[2]  = '{OP_SUB,  0, 2, 1'b0};
    dir[3]  = '{OP_AND,  2, 1, 1'b0};
    dir[4]  = '{OP_JMPZ, 0, 0, 1'b0};
    dir[5]  = '{OP_JMPZ, 0, 0, 1'b1};
    dir[6]  = '{OP_STAC, 0, 1, 1'b0};
    dir[7]  = '{OP_CLAC, 1, 0, 1'b0};
    dir[8]  = '{OP_JMP,  0, 0, 1'b1};
    dir[9]  = '{OP_NOP,  0, 0, 1'b0};
    dir[10] = '{OP_INAC, 0, 0, 1'b0};
    dir[11] = '{4'hB,    0, 0, 1'b0};
    dir[12] = '{OP_NOP,  1, 0, 1'b0};
    dir[13] = '{OP_HALT, 0, 0, 1'b0};

    rst = 1'b1; start = 1'b1; bus.mem_ack = 1'b0; ir_opcode = 4'h0; ac_zero = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    for (int k = 0; k < 10; k++)
      step(tbl[k].st, 1'b0, tbl[k].ack, tbl[k].op, tbl[k].az, 1'b1, tbl[k].exp, $sformatf("prog_inac_%0d", k));
    cur_op = 4'hF;

    do_reset();
    go();
    for (int k = 0; k < 14; k++) exec(dir[k], $sformatf("dir_%0d", k));

    // Reset lands on the second wait cycle of an LDAC memory access.
    do_reset();
    go();
    step(1'b0, 1'b0, 1'b1, cur_op, 1'b0, 1'b1, e(10'b1001100000, 2'b11, 3'b100), "rmem_fack");
    cur_op = OP_LDAC;
    step(1'b0, 1'b0, 1'b0, cur_op, 1'b0, 1'b1, e(10'b0000000000, 2'b11, 3'b100), "rmem_decode");
    step(1'b0, 1'b0, 1'b0, cur_op, 1'b0, 1'b1, e(10'b1010000000, 2'b11, 3'b100), "rmem_wait1");
    step(1'b0, 1'b1, 1'b0, cur_op, 1'b0, 1'b1, e(10'b1010000000, 2'b11, 3'b100), "rmem_wait2_rst");
    step(1'b0, 1'b0, 1'b1, cur_op, 1'b0, 1'b1, e(10'b0000000000, 2'b11, 3'b000), "rmem_after_rst");
    step(1'b0, 1'b0, 1'b1, cur_op, 1'b0, 1'b1, e(10'b0000000000, 2'b11, 3'b000), "rmem_idle");
    model_ill = 1'b0;

    go();
    for (int n = 0; n < 150; n++) begin
      ri.op = 4'($urandom_range(0, 14));
      ri.fw = $urandom_range(0, 3);
      ri.mw = $urandom_range(0, 3);
      ri.az = 1'($urandom_range(0, 1));
      exec(ri, $sformatf("rnd_%0d", n));
    end
    ri = '{OP_HALT, 1, 0, 1'b0};
    exec(ri, "rnd_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ac_ctrl.md
# ac_ctrl

Control unit sequencing the 12-bit accumulator datapath of the processor. Runs a fetch/decode/memory loop from a shared instruction/data memory. Drives the accumulator's load/ALU/increment/clear strobes, PC/IR control and the ALU operation select. Sits between the memory port, IR/PC registers and the `ac` + ALU datapath.

## Interface
Parameters:
- `OPW`, 4, opcode width (IR[15:12]); address field IR[11:0] is routed by the datapath, not by this block.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  leave IDLE and begin fetching at the current PC.
- `ir_opcode`  in  OPW  opcode of the currently latched IR.
- `ac_zero`  in  1  accumulator == 0.
- `mem_ack`  in  1  memory completion; may be high in the first `mem_req` cycle (zero-wait).
- `mem_req`  out  1  memory access request; held until `mem_ack`.
- `mem_we`  out  1  write qualifier; valid only while `mem_req`.
- `addr_sel`  out  1  0 = PC drives address, 1 = IR[11:0] drives address.
- `ir_load`, `pc_inc`, `pc_load`  out  1 each  single-cycle strobes.
- `ac_write_en`, `ac_alu_to_ac`, `ac_inc_en`, `ac_clr_en`  out  1 each  accumulator strobes.
- `alu_op`  out  2  00 ADD, 01 SUB, 10 AND, 11 PASS.
- `busy`, `halted`, `illegal`  out  1 each  status.

## Operation
- States: IDLE, FETCH, DECODE, MEM, HALT.
- IDLE: `start` -> FETCH; other inputs ignored.
- FETCH: `mem_req`=1, `addr_sel`=0, `mem_we`=0. In the `mem_ack` cycle: `ir_load`=1, `pc_inc`=1; next state DECODE.
- DECODE (exactly 1 cycle). Actions by opcode:
  - 0 NOP: none -> FETCH.
  - 6 INAC: `ac_inc_en` -> FETCH.
  - 7 CLAC: `ac_clr_en` -> FETCH.
  - 8 JMP: `pc_load` -> FETCH.
  - 9 JMPZ: `pc_load` only if `ac_zero` -> FETCH.
  - 1 LDAC, 2 STAC, 3 ADD, 4 SUB, 5 AND: -> MEM.
  - F HALT: -> HALT.
  - Any other opcode: sets sticky `illegal`, otherwise treated as NOP.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=1 only for STAC. In the `mem_ack` cycle:
  - LDAC: `ac_write_en`.
  - ADD/SUB/AND: `ac_alu_to_ac` with `alu_op` = 00/01/10.
  - STAC: no AC strobe.
  - Next state: FETCH.
- `alu_op`=11 (PASS) whenever no ALU instruction is in MEM.
- HALT: `halted`=1. Left only by `rst`; `start` is ignored.
- `busy`=1 in FETCH, DECODE and MEM.
- Invariant: at most one of the four AC strobes is high in any cycle. `pc_inc` and `pc_load` are never high together.

## Timing
- Reset: state IDLE; all outputs 0, except `alu_op`=11. `illegal` and `halted` are cleared.
- Reset during FETCH/MEM: `mem_req` is low in the cycle after the `rst` edge. The abandoned transaction produces no strobes.
- All outputs are decoded from registered state plus `mem_ack`/`ir_opcode`/`ac_zero` (Mealy on ack). Strobes are 1 cycle wide.
- Zero-wait memory latencies:
  - Register-class instruction: 2 cycles (FETCH, DECODE).
  - Memory-class instruction: 3 cycles.
- Each wait cycle with `mem_ack` low adds 1 cycle. Outputs are stable while waiting.
- `start` in the same cycle as `rst`: reset wins.
- `mem_ack` outside FETCH/MEM is ignored.

## Structure
- Shared package `ac_pkg` holds:
  - Opcode constants (NOP..HALT).
  - State enum.
  - `alu_op` encodings.
  - Address-select constants.
- One combinational sub-module `ac_decode` maps `ir_opcode` to instruction class (reg/mem/jump/halt/illegal), `alu_op` and `mem_we`. The FSM stays in `ac_ctrl`.

## Test plan
- Reset then `start`, zero-wait memory, program INAC, INAC, HALT -> two `ac_inc_en` pulses 2 cycles apart, `halted`=1 on cycle 7, `busy`=0 afterwards.
- LDAC with `mem_ack` delayed 3 cycles -> `mem_req`/`addr_sel`=1 held 4 cycles. Single `ac_write_en` in the ack cycle, no other AC strobe.
- ADD, SUB, AND each -> `ac_alu_to_ac` with `alu_op` 00, 01, 10 respectively. `alu_op`=11 in all other cycles.
- JMPZ with `ac_zero`=0, then with `ac_zero`=1 -> `pc_load` absent, then present. `pc_inc` asserted in both fetches.
- Opcode 0xB -> `illegal` set and held, execution continues to the next fetch. STAC -> `mem_we`=1 only in MEM.
- Assert `rst` on the 2nd wait cycle of a MEM access -> `mem_req`=0 the next cycle, no AC strobe, state IDLE. `start` asserted during HALT -> ignored.
